// File: rtl/issue_pkg.sv
// Shared issue-stage types: selection mode encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package issue_pkg;

    typedef enum logic {
        SEL_FIXED = 1'b0,
        SEL_RR    = 1'b1
    } issue_sel_mode_e;

endpackage

// File: rtl/issue_select_rr_rotate_pe.sv
// Rotated priority encoder: first set bit at or above base, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module rotate_pe #(
    parameter int els_p     = 16,
    parameter int lg_els_lp = $clog2(els_p)
) (
    input  logic [els_p-1:0]     vec_i,
    input  logic [lg_els_lp-1:0] base_i,
    output logic [lg_els_lp-1:0] addr_o,
    output logic                 v_o
);

    logic [lg_els_lp:0] pos;

    // Walk offsets from farthest to nearest so the nearest set bit to base wins.
    always_comb begin
        addr_o = '0;
        v_o    = 1'b0;
        pos    = '0;
        for (int i = els_p - 1; i >= 0; i--) begin
            pos = {1'b0, base_i} + (lg_els_lp + 1)'(i);
            if (pos >= (lg_els_lp + 1)'(els_p)) begin
                pos = pos - (lg_els_lp + 1)'(els_p);
            end
            if (vec_i[pos[lg_els_lp-1:0]]) begin
                addr_o = pos[lg_els_lp-1:0];
                v_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_select_rr.sv
// Multi-grant issue select: up to grants_p entries per cycle, fixed or round-robin order.
// Latency: 1 cycle req_i -> registered grant slots.
// Backpressure: grants hold bit-exact while v_o & ~ready_i; new selection loads when ~v_o | ready_i.
module issue_select_rr
    import issue_pkg::*;
#(
    parameter  int els_p     = 16,
    parameter  int grants_p  = 2,
    localparam int lg_els_lp = $clog2(els_p)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [els_p-1:0]                     req_i,
    input  logic                                 mode_i,
    input  logic                                 ready_i,
    output logic                                 v_o,
    output logic [grants_p-1:0]                  grant_v_o,
    output logic [grants_p-1:0][lg_els_lp-1:0]   grant_addr_o,
    output logic [els_p-1:0]                     grant_oh_o
);

    issue_sel_mode_e                         mode;
    logic [lg_els_lp-1:0]                    rr_ptr_r;
    logic [grants_p-1:0]                     grant_v_r;
    logic [grants_p-1:0][lg_els_lp-1:0]      grant_addr_r;
    logic [els_p-1:0]                        grant_oh_r;

    logic                                    accept;
    logic                                    load;
    logic [els_p-1:0]                        eff;
    logic [lg_els_lp-1:0]                    base;

    logic [grants_p:0][els_p-1:0]            stage_vec;
    logic [grants_p-1:0]                     sel_v;
    logic [grants_p-1:0][lg_els_lp-1:0]      sel_addr;
    logic [els_p-1:0]                        sel_oh;

    logic [lg_els_lp-1:0]                    last_addr;
    logic [lg_els_lp:0]                      last_inc;
    logic [lg_els_lp-1:0]                    ptr_next;

    assign mode   = issue_sel_mode_e'(mode_i);
    assign v_o    = grant_v_r[0];
    assign accept = v_o & ready_i;
    assign load   = ~v_o | ready_i;

    // Entries being accepted now still show as requesting for one more cycle.
    assign eff  = req_i & ~(accept ? grant_oh_r : '0);
    assign base = (mode == SEL_RR) ? rr_ptr_r : '0;

    assign stage_vec[0] = eff;

    // Each stage takes the next set bit after the ones granted by earlier stages.
    for (genvar k = 0; k < grants_p; k++) begin : g_stage
        rotate_pe #(
            .els_p     (els_p),
            .lg_els_lp (lg_els_lp)
        ) u_pe (
            .vec_i  (stage_vec[k]),
            .base_i (base),
            .addr_o (sel_addr[k]),
            .v_o    (sel_v[k])
        );
        assign stage_vec[k+1] = stage_vec[k] & ~(els_p'(sel_v[k]) << sel_addr[k]);
    end

    // Every bit removed along the chain was granted to some slot.
    assign sel_oh = stage_vec[0] & ~stage_vec[grants_p];

    // Slots fill contiguously, so the last valid slot holds the farthest grant.
    always_comb begin
        last_addr = grant_addr_r[0];
        for (int k = 1; k < grants_p; k++) begin
            if (grant_v_r[k]) begin
                last_addr = grant_addr_r[k];
            end
        end
        last_inc = {1'b0, last_addr} + 1'b1;
        ptr_next = (last_inc == (lg_els_lp + 1)'(els_p)) ? '0 : last_inc[lg_els_lp-1:0];
    end

    // Output registers load on a free or draining slot set; pointer moves past accepted RR grants.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr_r     <= '0;
            grant_v_r    <= '0;
            grant_addr_r <= '0;
            grant_oh_r   <= '0;
        end else begin
            if (load) begin
                grant_v_r    <= sel_v;
                grant_addr_r <= sel_addr;
                grant_oh_r   <= sel_oh;
            end
            if (accept && (mode == SEL_RR)) begin
                rr_ptr_r <= ptr_next;
            end
        end
    end

    assign grant_v_o    = grant_v_r;
    assign grant_addr_o = grant_addr_r;
    assign grant_oh_o   = grant_oh_r;

endmodule

// File: tb/tb_issue_select_rr.sv
// Scoreboard bench for issue_select_rr with els_p=8, grants_p=2.
// Latency: expects grants one edge after inputs are applied.
// Backpressure: random ready_i exercises stall and hold.
module tb_issue_select_rr;

    localparam int ELS = 8;
    localparam int GR  = 2;

    typedef struct packed {
        logic [1:0] v;
        logic [2:0] a0;
        logic [2:0] a1;
        logic [7:0] oh;
    } exp_t;

    logic             clk_i;
    logic             reset_n_i;
    logic [ELS-1:0]   req_i;
    logic             mode_i;
    logic             ready_i;
    logic             v_o;
    logic [GR-1:0]    grant_v_o;
    logic [GR-1:0][2:0] grant_addr_o;
    logic [ELS-1:0]   grant_oh_o;

    int   vectors;
    int   miscompares;
    exp_t sb[$];
    exp_t m;
    int   m_ptr;

    issue_select_rr #(
        .els_p    (ELS),
        .grants_p (GR)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .req_i        (req_i),
        .mode_i       (mode_i),
        .ready_i      (ready_i),
        .v_o          (v_o),
        .grant_v_o    (grant_v_o),
        .grant_addr_o (grant_addr_o),
        .grant_oh_o   (grant_oh_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference: list requesting entries in scan order from the base, first two win.
    task automatic apply_now(input logic [7:0] r, input logic md, input logic rd);
        logic [7:0] eff;
        exp_t       nx;
        int         base;
        int         n;
        int         last;
        int         j;
        logic       vo, acc, ld;
        req_i   = r;
        mode_i  = md;
        ready_i = rd;
        vo  = m.v[0];
        acc = vo && rd;
        ld  = !vo || rd;
        base = md ? m_ptr : 0;
        if (acc && md) begin
            last  = m.v[1] ? int'(m.a1) : int'(m.a0);
            m_ptr = (last + 1) % ELS;
        end
        eff = r & ~(acc ? m.oh : 8'h00);
        if (ld) begin
            nx = '0;
            n  = 0;
            for (int i = 0; i < ELS; i++) begin
                j = (base + i) % ELS;
                if (eff[j] && n < GR) begin
                    if (n == 0) nx.a0 = j[2:0];
                    else        nx.a1 = j[2:0];
                    nx.v[n]  = 1'b1;
                    nx.oh[j] = 1'b1;
                    n++;
                end
            end
            m = nx;
        end
        sb.push_back(m);
    endtask

    task automatic drive(input logic [7:0] r, input logic md, input logic rd);
        @(posedge clk_i);
        #3;
        apply_now(r, md, rd);
    endtask

    task automatic chk(input string name, input logic [1:0] v, input logic [2:0] a0,
                       input logic [2:0] a1, input logic [7:0] oh);
        vectors++;
        if (v_o !== v[0] || grant_v_o !== v || grant_addr_o[0] !== a0 ||
            grant_addr_o[1] !== a1 || grant_oh_o !== oh) begin
            miscompares++;
            $display("FAIL %s: got v=%b a0=%0d a1=%0d oh=%b, want v=%b a0=%0d a1=%0d oh=%b",
                     name, grant_v_o, grant_addr_o[0], grant_addr_o[1], grant_oh_o,
                     v, a0, a1, oh);
        end
    endtask

    // Monitor: just after each edge, compare outputs with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (reset_n_i && sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (v_o !== e.v[0] || grant_v_o !== e.v || grant_addr_o[0] !== e.a0 ||
                    grant_addr_o[1] !== e.a1 || grant_oh_o !== e.oh) begin
                    miscompares++;
                    $display("FAIL scoreboard t=%0t: got v=%b a0=%0d a1=%0d oh=%b, want v=%b a0=%0d a1=%0d oh=%b",
                             $time, grant_v_o, grant_addr_o[0], grant_addr_o[1], grant_oh_o,
                             e.v, e.a0, e.a1, e.oh);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       md;
        logic [7:0] r;
        vectors     = 0;
        miscompares = 0;
        m           = '0;
        m_ptr       = 0;
        reset_n_i   = 1'b0;
        req_i       = 8'hFF;
        mode_i      = 1'b0;
        ready_i     = 1'b1;

        // Reset held with every entry requesting.
        @(posedge clk_i);
        #3;
        chk("reset_hold", 2'b00, 3'd0, 3'd0, 8'h00);
        @(posedge clk_i);
        #3;
        reset_n_i = 1'b1;
        apply_now(8'hFF, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b1);
        chk("reset_first_grant", 2'b11, 3'd0, 3'd1, 8'h03);

        // Fixed priority with accepted grants masked.
        drive(8'hA6, 1'b0, 1'b1);
        drive(8'hA6, 1'b0, 1'b1);
        chk("fixed_cycle1", 2'b11, 3'd1, 3'd2, 8'h06);
        drive(8'hA6, 1'b0, 1'b1);
        chk("fixed_cycle2", 2'b11, 3'd5, 3'd7, 8'hA0);

        // Walk the pointer to 6, then check the wrap.
        drive(8'h20, 1'b1, 1'b1);
        drive(8'h00, 1'b1, 1'b1);
        drive(8'h41, 1'b1, 1'b1);
        drive(8'h00, 1'b1, 1'b1);
        chk("rr_wrap", 2'b11, 3'd6, 3'd0, 8'h41);
        drive(8'hFF, 1'b1, 1'b1);
        drive(8'h5A, 1'b1, 1'b0);
        chk("rr_ptr_after_wrap", 2'b11, 3'd1, 3'd2, 8'h06);

        // Stall: outputs hold while requests toggle.
        drive(8'hA5, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 1'b0);
        chk("stall_hold", 2'b11, 3'd1, 3'd2, 8'h06);
        drive(8'hF0, 1'b1, 1'b1);
        drive(8'h00, 1'b1, 1'b0);
        chk("stall_release", 2'b11, 3'd4, 3'd5, 8'h30);

        // Partial fill.
        drive(8'h00, 1'b0, 1'b1);
        drive(8'h10, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b0);
        chk("partial_fill", 2'b01, 3'd4, 3'd0, 8'h10);

        // Asynchronous reset between edges while a grant is presented.
        #1;
        reset_n_i = 1'b0;
        sb.delete();
        m     = '0;
        m_ptr = 0;
        #1;
        chk("async_reset", 2'b00, 3'd0, 3'd0, 8'h00);
        @(posedge clk_i);
        #3;
        reset_n_i = 1'b1;
        apply_now(8'hFF, 1'b1, 1'b1);
        drive(8'h00, 1'b1, 1'b0);
        chk("ptr_after_reset", 2'b11, 3'd0, 3'd1, 8'h03);

        // Randomized traffic against the reference.
        md = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
            if ($urandom_range(0, 15) == 0) r = 8'h00;
            if ($urandom_range(0, 7) == 0) md = ~md;
            drive(r, md, ($urandom_range(0, 3) != 0));
        end
        drive(8'h00, md, 1'b1);
        @(posedge clk_i);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
